register_file_be: RTL

REGISTER_FILE_BE -- requirements
Module: register_file_be

---
 rtl/register_file_be.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/register_file_be.sv
// Multi-port register file with byte-lane writes, two registered read ports
// and a one-entry-per-cycle bulk-clear sweep that blocks writes while running.
module register_file_be #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH/8-1:0]   wbe,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re0,
    input  logic                 re1,
    input  logic [AW-1:0]        raddr0,
    input  logic [AW-1:0]        raddr1,
    output logic [WIDTH-1:0]     rdata0,
    output logic [WIDTH-1:0]     rdata1,
    input  logic                 clr,
    output logic                 busy
);

    localparam int NB = WIDTH / 8;
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [AW-1:0]     cnt_r;
    logic [AW-1:0]     cnt_nxt_s;
    logic [WIDTH-1:0]  mem_r     [DEPTH];
    logic [WIDTH-1:0]  mem_nxt_s [DEPTH];
    logic [WIDTH-1:0]  rdata0_r;
    logic [WIDTH-1:0]  rdata1_r;
    logic              busy_r;
    logic              wr_acc_s;

    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_val,
        input logic [WIDTH-1:0] new_val,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Sweep FSM next-state and counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (clr) begin
                    state_nxt_s = CLEAR;
                    cnt_nxt_s   = {AW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            CLEAR: begin
                cnt_nxt_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {AW{1'b0}};
            end
        endcase
    end

    // Post-edge entry values; reads sample these so they see same-edge writes and clears.
    always_comb begin
        wr_acc_s = we & (state_r == IDLE);
        for (int i = 0; i < DEPTH; i++) begin
            mem_nxt_s[i] = mem_r[i];
            if ((state_r == CLEAR) && (cnt_r == AW'(i))) begin
                mem_nxt_s[i] = {WIDTH{1'b0}};
            end else if (wr_acc_s && (waddr == AW'(i))) begin
                mem_nxt_s[i] = merge_lanes(mem_r[i], wdata, wbe);
            end else begin
                mem_nxt_s[i] = mem_r[i];
            end
        end
    end

    // State, storage and read-data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            cnt_r    <= {AW{1'b0}};
            busy_r   <= 1'b0;
            rdata0_r <= {WIDTH{1'b0}};
            rdata1_r <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == CLEAR);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= mem_nxt_s[i];
            end
            if (re0) begin
                rdata0_r <= mem_nxt_s[raddr0];
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (re1) begin
                rdata1_r <= mem_nxt_s[raddr1];
            end else begin
                rdata1_r <= rdata1_r;
            end
        end
    end

    assign rdata0 = rdata0_r;
    assign rdata1 = rdata1_r;
    assign busy   = busy_r;

endmodule
